// File: rtl/maze_mem_pkg.sv
// Shared types for the maze map storage: clear-sweep FSM states and the cell
// encoding used by the solver and the move/display logic.
package maze_mem_pkg;

  localparam int unsigned CellW = 2;

  typedef enum logic [0:0] {
    StClear,
    StReady
  } maze_mem_state_e;

  localparam logic [CellW-1:0] CellFree    = 2'b00;
  localparam logic [CellW-1:0] CellWall    = 2'b01;
  localparam logic [CellW-1:0] CellVisited = 2'b10;
  localparam logic [CellW-1:0] CellPath    = 2'b11;

endpackage

// File: rtl/maze_map_mem_if.sv
// Request/response bundle for maze_map_mem: solver port A, read-only port B,
// clear request and status strobes.
interface maze_map_mem_if #(
  parameter int unsigned CELL_W = 2,
  parameter int unsigned ADDR_W = 16
) ();

  logic              clr_req;
  logic              busy;
  logic              a_we;
  logic              a_re;
  logic [ADDR_W-1:0] a_adr;
  logic [CELL_W-1:0] a_din;
  logic [CELL_W-1:0] a_dout;
  logic              a_valid;
  logic              b_re;
  logic [ADDR_W-1:0] b_adr;
  logic [CELL_W-1:0] b_dout;
  logic              b_valid;
  logic              adr_err;

  modport master (
    output clr_req, a_we, a_re, a_adr, a_din, b_re, b_adr,
    input  busy, a_dout, a_valid, b_dout, b_valid, adr_err
  );

  modport slave (
    input  clr_req, a_we, a_re, a_adr, a_din, b_re, b_adr,
    output busy, a_dout, a_valid, b_dout, b_valid, adr_err
  );

endinterface

// File: rtl/maze_mem_clear_ctrl.sv
// Clear-sweep controller: walks every cell once after reset or on clr_req and
// reports busy while the sweep owns the array write port.
module maze_mem_clear_ctrl
  import maze_mem_pkg::*;
#(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned IdxW  = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr_req,
  output logic            busy,
  output logic            sweep_we,
  output logic [IdxW-1:0] sweep_adr
);

  localparam logic [IdxW-1:0] LastIdx = IdxW'(DEPTH - 1);

  maze_mem_state_e state_q, state_d;
  logic [IdxW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StClear;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    busy      = 1'b0;
    sweep_we  = 1'b0;
    sweep_adr = cnt_q;
    unique case (state_q)
      StClear: begin
        busy     = 1'b1;
        sweep_we = 1'b1;
        if (cnt_q == LastIdx) begin
          state_d = StReady;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StReady: begin
        if (clr_req) begin
          state_d = StClear;
          cnt_d   = '0;
        end
      end
      default: state_d = StClear;
    endcase
  end

endmodule

// File: rtl/maze_map_mem.sv
// Maze map storage: registered read/write port A, read-only port B with
// write-first bypass from A, range checking and a hardware clear sweep.
module maze_map_mem
  import maze_mem_pkg::*;
#(
  parameter int unsigned       CELL_W   = 2,
  parameter int unsigned       DEPTH    = 256,
  parameter int unsigned       ADDR_W   = 16,
  parameter logic [CELL_W-1:0] INIT_VAL = CELL_W'(CellFree)
) (
  input logic          clk,
  input logic          rst,
  maze_map_mem_if.slave bus
);

  localparam int unsigned     IdxW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so DEPTH itself is representable when DEPTH == 2^ADDR_W.
  localparam logic [ADDR_W:0] DepthExt = (ADDR_W + 1)'(DEPTH);

  logic              busy;
  logic              sweep_we;
  logic [IdxW-1:0]   sweep_adr;

  logic              accept;
  logic              a_in, b_in;
  logic [IdxW-1:0]   a_idx, b_idx;
  logic              a_wr, a_rd, b_rd, bypass, err;
  logic [CELL_W-1:0] a_rdata, b_rdata;

  logic [CELL_W-1:0] mem_q [DEPTH];
  logic [CELL_W-1:0] a_dout_q, b_dout_q;
  logic              a_valid_q, b_valid_q, adr_err_q;

  maze_mem_clear_ctrl #(
    .DEPTH(DEPTH),
    .IdxW (IdxW)
  ) u_clear_ctrl (
    .clk      (clk),
    .rst      (rst),
    .clr_req  (bus.clr_req),
    .busy     (busy),
    .sweep_we (sweep_we),
    .sweep_adr(sweep_adr)
  );

  // A clear request wins over any port request sampled on the same edge.
  assign accept = !busy && !bus.clr_req;

  assign a_in  = {1'b0, bus.a_adr} < DepthExt;
  assign b_in  = {1'b0, bus.b_adr} < DepthExt;
  assign a_idx = bus.a_adr[IdxW-1:0];
  assign b_idx = bus.b_adr[IdxW-1:0];

  assign a_wr   = accept && bus.a_we && a_in;
  assign a_rd   = accept && !bus.a_we && bus.a_re;
  assign b_rd   = accept && bus.b_re;
  assign bypass = a_wr && (bus.a_adr == bus.b_adr);
  assign err    = accept && (((bus.a_we || bus.a_re) && !a_in) || (bus.b_re && !b_in));

  always_comb begin
    a_rdata = INIT_VAL;
    b_rdata = INIT_VAL;
    if (a_in) begin
      a_rdata = mem_q[a_idx];
    end
    if (b_in) begin
      b_rdata = bypass ? bus.a_din : mem_q[b_idx];
    end
  end

  // Array contents are established by the sweep, so the array itself has no reset.
  always_ff @(posedge clk) begin
    if (sweep_we) begin
      mem_q[sweep_adr] <= INIT_VAL;
    end else if (a_wr) begin
      mem_q[a_idx] <= bus.a_din;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_dout_q  <= '0;
      b_dout_q  <= '0;
      a_valid_q <= 1'b0;
      b_valid_q <= 1'b0;
      adr_err_q <= 1'b0;
    end else begin
      a_valid_q <= a_rd;
      b_valid_q <= b_rd;
      adr_err_q <= err;
      if (a_rd) begin
        a_dout_q <= a_rdata;
      end
      if (b_rd) begin
        b_dout_q <= b_rdata;
      end
    end
  end

  assign bus.busy    = busy;
  assign bus.a_dout  = a_dout_q;
  assign bus.a_valid = a_valid_q;
  assign bus.b_dout  = b_dout_q;
  assign bus.b_valid = b_valid_q;
  assign bus.adr_err = adr_err_q;

endmodule

// File: tb/tb_maze_map_mem.sv
// Directed bench for maze_map_mem: one 256-cell and one 200-cell instance,
// inputs driven and outputs sampled on the falling clock edge.
module tb_maze_map_mem;
  import maze_mem_pkg::*;

  localparam logic [1:0] InitA = CellVisited;  // 2'b10 for the 256-cell instance
  localparam logic [1:0] InitB = CellWall;     // 2'b01 for the 200-cell instance

  logic clk = 1'b0;
  logic rst_a, rst_b;
  int   checks   = 0;
  int   failures = 0;
  int   n, seen;

  always #5 clk = ~clk;

  maze_map_mem_if #(.CELL_W(2), .ADDR_W(16)) ma ();
  maze_map_mem_if #(.CELL_W(2), .ADDR_W(16)) mb ();

  maze_map_mem #(
    .CELL_W(2), .DEPTH(256), .ADDR_W(16), .INIT_VAL(InitA)
  ) dut_a (
    .clk(clk),
    .rst(rst_a),
    .bus(ma)
  );

  maze_map_mem #(
    .CELL_W(2), .DEPTH(200), .ADDR_W(16), .INIT_VAL(InitB)
  ) dut_b (
    .clk(clk),
    .rst(rst_b),
    .bus(mb)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle_all();
    ma.clr_req = 0; ma.a_we = 0; ma.a_re = 0; ma.a_adr = '0; ma.a_din = '0;
    ma.b_re = 0; ma.b_adr = '0;
    mb.clr_req = 0; mb.a_we = 0; mb.a_re = 0; mb.a_adr = '0; mb.a_din = '0;
    mb.b_re = 0; mb.b_adr = '0;
  endtask

  // Counts falling edges until busy drops, bounded so a stuck sweep still ends.
  task automatic count_busy(input bit sel, output int cnt);
    cnt = 0;
    while (((sel ? mb.busy : ma.busy) === 1'b1) && cnt < 1000) begin
      step();
      cnt++;
    end
  endtask

  initial begin
    idle_all();
    rst_a = 1'b0;
    rst_b = 1'b0;
    repeat (3) step();

    check("rst_busy", 32'(ma.busy), 1);
    check("rst_a_dout", 32'(ma.a_dout), 0);
    check("rst_b_dout", 32'(ma.b_dout), 0);
    check("rst_valids_err", {29'd0, ma.a_valid, ma.b_valid, ma.adr_err}, 0);
    check("rst_busy_200", 32'(mb.busy), 1);

    // Requests and clr_req during the sweep must be ignored.
    rst_a = 1'b1;
    ma.b_re = 1; ma.b_adr = 16'd0; ma.clr_req = 1;
    n = 0; seen = 0;
    while (ma.busy === 1'b1 && n < 1000) begin
      step();
      n++;
      if (ma.b_valid || ma.adr_err) seen++;
    end
    idle_all();
    check("sweep_cycles", 32'(n), 256);
    check("sweep_no_strobe", 32'(seen), 0);

    // Back-to-back B reads after the sweep.
    ma.b_re = 1; ma.b_adr = 16'd0;   step();
    check("b_rd0", {30'd0, ma.b_dout}, {30'd0, InitA});
    check("b_rd0_v", 32'(ma.b_valid), 1);
    ma.b_adr = 16'd128;              step();
    check("b_rd128", {30'd0, ma.b_dout}, {30'd0, InitA});
    check("b_rd128_v", 32'(ma.b_valid), 1);
    ma.b_adr = 16'd255;              step();
    check("b_rd255", {30'd0, ma.b_dout}, {30'd0, InitA});
    check("b_rd255_v", 32'(ma.b_valid), 1);
    ma.b_re = 0;                     step();
    check("b_valid_falls", 32'(ma.b_valid), 0);
    check("b_dout_holds", {30'd0, ma.b_dout}, {30'd0, InitA});

    // Write 37 then read on both ports.
    ma.a_we = 1; ma.a_adr = 16'd37; ma.a_din = 2'b11; step();
    check("wr37_no_avalid", 32'(ma.a_valid), 0);
    ma.a_we = 0; ma.a_re = 1; ma.b_re = 1; ma.b_adr = 16'd37; step();
    check("rd37_a", {30'd0, ma.a_dout}, 32'd3);
    check("rd37_b", {30'd0, ma.b_dout}, 32'd3);
    check("rd37_valids", {30'd0, ma.a_valid, ma.b_valid}, 32'd3);
    idle_all(); step();
    check("a_valid_falls", 32'(ma.a_valid), 0);
    check("a_dout_holds", {30'd0, ma.a_dout}, 32'd3);

    // Same-cycle write-first bypass; write beats read on port A.
    ma.a_we = 1; ma.a_re = 1; ma.a_adr = 16'd5; ma.a_din = 2'b10;
    ma.b_re = 1; ma.b_adr = 16'd5; step();
    check("bypass_b_dout", {30'd0, ma.b_dout}, 32'd2);
    check("bypass_b_valid", 32'(ma.b_valid), 1);
    check("we_re_no_avalid", 32'(ma.a_valid), 0);
    check("bypass_no_err", 32'(ma.adr_err), 0);
    idle_all();
    ma.a_we = 1; ma.a_adr = 16'd10; ma.a_din = 2'b01; step();
    ma.a_adr = 16'd11; ma.a_din = 2'b11; step();
    ma.a_we = 0;

    // Interleaved reads every cycle on both ports.
    ma.a_re = 1; ma.a_adr = 16'd11; ma.b_re = 1; ma.b_adr = 16'd10; step();
    check("b2b1_a", {29'd0, ma.a_valid, ma.a_dout}, 32'h7);
    check("b2b1_b", {29'd0, ma.b_valid, ma.b_dout}, 32'h5);
    ma.a_adr = 16'd10; ma.b_adr = 16'd11; step();
    check("b2b2_a", {29'd0, ma.a_valid, ma.a_dout}, 32'h5);
    check("b2b2_b", {29'd0, ma.b_valid, ma.b_dout}, 32'h7);
    ma.a_adr = 16'd5; ma.b_adr = 16'd37; step();
    check("b2b3_a", {29'd0, ma.a_valid, ma.a_dout}, 32'h6);
    check("b2b3_b", {29'd0, ma.b_valid, ma.b_dout}, 32'h7);
    idle_all();

    // 293 aliases 37 if the address were truncated to 8 bits.
    ma.a_we = 1; ma.a_adr = 16'd293; ma.a_din = 2'b00; step();
    check("oor_wr_err", 32'(ma.adr_err), 1);
    ma.a_we = 0; ma.a_re = 1; ma.a_adr = 16'd37; ma.b_re = 1; ma.b_adr = 16'd300; step();
    check("oor_no_alias", {30'd0, ma.a_dout}, 32'd3);
    check("oor_b_init", {29'd0, ma.b_valid, ma.b_dout}, {29'd0, 1'b1, InitA});
    check("oor_b_err", 32'(ma.adr_err), 1);
    idle_all(); step();
    check("err_one_cycle", 32'(ma.adr_err), 0);

    // clr_req drops a same-cycle write, then reruns the full sweep.
    ma.clr_req = 1; ma.a_we = 1; ma.a_adr = 16'd9; ma.a_din = 2'b01; step();
    idle_all();
    count_busy(1'b0, n);
    check("clr_sweep_cycles", 32'(n), 256);
    ma.a_re = 1; ma.a_adr = 16'd9; ma.b_re = 1; ma.b_adr = 16'd37; step();
    check("clr_rd9", {29'd0, ma.a_valid, ma.a_dout}, {29'd0, 1'b1, InitA});
    check("clr_rd37", {29'd0, ma.b_valid, ma.b_dout}, {29'd0, 1'b1, InitA});
    idle_all();

    // Reset pulsed while the sweep counter is at 100.
    ma.a_we = 1; ma.a_adr = 16'd200; ma.a_din = 2'b11; step();
    idle_all();
    ma.clr_req = 1; step();
    ma.clr_req = 0;
    repeat (100) step();
    #2 rst_a = 1'b0;
    #1;
    check("midrst_busy", 32'(ma.busy), 1);
    check("midrst_douts", {28'd0, ma.a_dout, ma.b_dout}, 0);
    check("midrst_strobes", {29'd0, ma.a_valid, ma.b_valid, ma.adr_err}, 0);
    step();
    rst_a = 1'b1;
    count_busy(1'b0, n);
    check("midrst_sweep_cycles", 32'(n), 256);
    ma.b_re = 1; ma.b_adr = 16'd200; step();
    check("midrst_rd200", {29'd0, ma.b_valid, ma.b_dout}, {29'd0, 1'b1, InitA});
    idle_all();

    // 200-cell instance: non-power-of-two depth and range edges.
    step();
    rst_b = 1'b1;
    count_busy(1'b1, n);
    check("d200_sweep_cycles", 32'(n), 200);
    mb.a_we = 1; mb.a_adr = 16'd250; mb.a_din = 2'b11; step();
    check("d200_wr250_err", 32'(mb.adr_err), 1);
    mb.a_adr = 16'd261; step();
    check("d200_wr261_err", 32'(mb.adr_err), 1);
    mb.a_adr = 16'd199; mb.a_din = 2'b10; step();
    check("d200_wr199_no_err", 32'(mb.adr_err), 0);
    mb.a_we = 0; mb.b_re = 1; mb.b_adr = 16'd199; mb.a_re = 1; mb.a_adr = 16'd5; step();
    check("d200_rd199", {29'd0, mb.b_valid, mb.b_dout}, 32'h6);
    check("d200_rd5_no_alias", {29'd0, mb.a_valid, mb.a_dout}, {29'd0, 1'b1, InitB});
    mb.a_adr = 16'd200; mb.b_adr = 16'd250; step();
    check("d200_rd200", {29'd0, mb.a_valid, mb.a_dout}, {29'd0, 1'b1, InitB});
    check("d200_rd250", {29'd0, mb.b_valid, mb.b_dout}, {29'd0, 1'b1, InitB});
    check("d200_rd_err", 32'(mb.adr_err), 1);
    idle_all(); step();
    check("d200_err_falls", 32'(mb.adr_err), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/maze_map_mem.md
# maze_map_mem

Parametrised maze-map storage for the rat-in-maze datapath: one read/write port (A) for the solver and one read-only port (B) for the move/display logic. Registered one-cycle reads with valid strobes, write-first bypass between ports, address-range checking, and a hardware clear sweep that fills every cell with a programmable initial value after reset or on request.

## Interface
- `CELL_W`, 2: bits per maze cell.
- `DEPTH`, 256: number of cells; need not be a power of two.
- `ADDR_W`, 16: address port width; must satisfy 2^ADDR_W >= DEPTH.
- `INIT_VAL`, 2'b00: value written to every cell by the clear sweep.
---
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `clr_req`  in  1  one-cycle pulse; starts a clear sweep when idle.
- `busy`  out  1  high while a clear sweep runs; requests are ignored.
- `a_we`  in  1  port A write enable.
- `a_re`  in  1  port A read enable.
- `a_adr`  in  ADDR_W  port A address.
- `a_din`  in  CELL_W  port A write data.
- `a_dout`  out  CELL_W  port A read data, registered.
- `a_valid`  out  1  one-cycle strobe; `a_dout` updated.
- `b_re`  in  1  port B read enable.
- `b_adr`  in  ADDR_W  port B address.
- `b_dout`  out  CELL_W  port B read data, registered.
- `b_valid`  out  1  one-cycle strobe; `b_dout` updated.
- `adr_err`  out  1  one-cycle strobe; an accepted request had address >= DEPTH.

## Operation
- FSM states: CLEAR, READY. Reset enters CLEAR with sweep counter 0.
- CLEAR: each cycle writes `INIT_VAL` to cell[counter] and increments the counter. After writing cell DEPTH-1, the next state is READY. `busy`=1 throughout. `a_*`, `b_*` and `clr_req` are ignored; no valid or err strobes.
- READY: `busy`=0. `clr_req`=1 moves to CLEAR with counter 0, and any port request in that same cycle is dropped.
- Port A priority: `a_we` beats `a_re`. Write and read asserted together performs the write only; `a_valid` stays 0.
- Port B reads in parallel with port A. Write-first: if `a_we` and `b_re` target the same in-range address in the same cycle, `b_dout` returns `a_din`.
- Out of range (address >= DEPTH): a write is discarded; a read returns `INIT_VAL` with its valid strobe still asserted. `adr_err` pulses once per cycle if either port is out of range.
- `a_dout` and `b_dout` hold their last value between reads.
- Width rules: addresses are compared in full ADDR_W width, never truncated.

## Timing
- Reset values: `a_dout`=0, `b_dout`=0, `a_valid`=0, `b_valid`=0, `adr_err`=0, `busy`=1.
- The clear sweep takes exactly DEPTH cycles after reset release or after the `clr_req` edge. `busy` falls on the edge that writes cell DEPTH-1. The first request accepted is the one sampled on the following edge.
- Read latency: a request sampled at edge N drives dout, valid and err after edge N; valid falls after edge N+1 unless re-requested.
- Back-to-back reads on both ports are accepted every cycle with no bubbles.
- Write-then-read of the same address on consecutive cycles returns the new data.
- Reset asserted mid-sweep or mid-access: all outputs go to reset values immediately, and the sweep restarts from 0 on release.

## Structure
- Package `maze_mem_pkg`: FSM state enum (CLEAR, READY) and cell-encoding constants (FREE, WALL, VISITED, PATH) shared with the solver.
- Sub-module `maze_mem_clear_ctrl`: FSM plus sweep counter. It exports `busy`, `sweep_we` and `sweep_adr` to the array/port logic in the top level.

## Test plan
- Reset release with DEPTH=256: `busy` stays high for 256 cycles; then a B read of each of addresses 0, 128 and 255 returns `INIT_VAL` with `b_valid` set.
- In READY, A writes 2'b11 to address 37; next cycle A reads 37 and B reads 37: both return 2'b11 one cycle later with both valids set.
- Same cycle: A writes 2'b10 to address 5, B reads 5 -> `b_dout`=2'b10; `a_we`+`a_re` together -> `a_valid`=0.
- DEPTH=200: A write to address 250 is dropped and `adr_err` pulses; B read of 250 returns `INIT_VAL` with `b_valid` and `adr_err` both set.
- `clr_req` in the same cycle as an A write of 2'b01 to address 9: the write is dropped, `busy` is high for DEPTH cycles, and address 9 then reads `INIT_VAL`.
- Reset pulsed during a sweep at counter 100: outputs return to reset values and the sweep reruns the full DEPTH cycles.
